nco_phase_core: RTL and testbench

Parametrised numerically-controlled oscillator core: a fractional phase accumulator with programmable modulus indexes a waveform table split across two internal dual-port banks. Table contents are host-loaded through a write port. The core replaces the fixed integer ratio counter with a fine-resolution tuning word and a runtime table length. It sits between the host register interface and the DAC/modulator datapath and emits one registered sample per enabled cycle.

---
 rtl/nco_phase_core.sv | 231 +++++++++++++++++++++++
 tb/tb_nco_phase_core.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_phase_core.sv
// -----------------------------------------------------------------------------
// nco_phase_core
//
// Numerically-controlled oscillator core. A fractional phase accumulator with
// a runtime-programmable modulus (len samples) indexes a waveform table held
// in two dual-port banks. The host loads the table through a write port that
// may run at the same time as playback.
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   en          advance phase and issue a table read this cycle
//   phase_clr   force phase to 0 on the next edge (priority over en)
//   ftw         tuning word added to the phase per enabled cycle
//   len         table length in samples (0 behaves as 1)
//   wr_en       table write strobe
//   wr_addr     table write index, MSB selects the bank
//   wr_data     table write data
//   sine_out    registered sample
//   sine_valid  sine_out carries a newly issued sample this cycle
//   wrap        one-cycle pulse, the phase wrapped on the preceding edge
//
// Pipeline
//   edge k   : bank read of index I, bank select / valid captured
//   edge k+1 : bank read data registered
//   edge k+2 : bank mux result registered into sine_out
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// nco_bank
//
// One table bank: a simple dual-port RAM with one write port and one
// registered read port. A read and a write to the same address in the same
// cycle return the old contents. Contents are never reset.
//
// Ports
//   clk    clock
//   we     write strobe
//   waddr  write address
//   wdata  write data
//   re     read enable
//   raddr  read address
//   rdata  registered read data
// -----------------------------------------------------------------------------
module nco_bank #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Non-blocking write and read in the same process give read-before-write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

module nco_phase_core #(
  parameter int ADDR_W = 8,
  parameter int FRAC_W = 8,
  parameter int DATA_W = 16,
  localparam int IDX_W = ADDR_W + 1,
  localparam int PH_W  = IDX_W + FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              phase_clr,
  input  logic [PH_W-1:0]   ftw,
  input  logic [IDX_W:0]    len,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] sine_out,
  output logic              sine_valid,
  output logic              wrap
);

  // ---------------------------------------------------------------------------
  // Phase accumulator
  // ---------------------------------------------------------------------------
  logic [PH_W-1:0]   phase;
  logic [PH_W-1:0]   phase_nxt;
  logic [IDX_W:0]    len_eff;
  logic [PH_W:0]     modulus;
  logic [PH_W:0]     phase_ext;
  logic [PH_W:0]     ftw_ext;
  logic [PH_W:0]     sum;
  logic [PH_W-1:0]   step;
  logic              out_of_range;
  logic              issue;
  logic              wrap_nxt;

  always_comb begin
    len_eff      = (len == '0) ? {{IDX_W{1'b0}}, 1'b1} : len;
    modulus      = {len_eff, {FRAC_W{1'b0}}};
    phase_ext    = {1'b0, phase};
    ftw_ext      = {1'b0, ftw};
    // A tuning word at or beyond one full table period would skip whole
    // periods; it is treated as zero so the phase simply holds.
    step         = (ftw_ext < modulus) ? ftw : '0;
    sum          = phase_ext + {1'b0, step};
    // len can shrink underneath a running phase; such a phase has no valid
    // table entry, so no read goes out and the phase restarts at 0.
    out_of_range = (phase_ext >= modulus);
    issue        = en & ~out_of_range;

    phase_nxt = phase;
    wrap_nxt  = 1'b0;
    if (phase_clr) begin
      phase_nxt = '0;
    end else if (out_of_range) begin
      phase_nxt = '0;
      wrap_nxt  = 1'b1;
    end else if (en) begin
      // Both phase and step are below modulus, so a single subtraction
      // brings the sum back into range.
      if (sum >= modulus) begin
        phase_nxt = PH_W'(sum - modulus);
        wrap_nxt  = 1'b1;
      end else begin
        phase_nxt = sum[PH_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      wrap  <= 1'b0;
    end else begin
      phase <= phase_nxt;
      wrap  <= wrap_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Table banks
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_bank;
  logic              we0;
  logic              we1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;

  assign rd_addr = phase[FRAC_W +: ADDR_W];
  assign rd_bank = phase[PH_W-1];
  assign we0     = wr_en & ~wr_addr[ADDR_W];
  assign we1     = wr_en &  wr_addr[ADDR_W];

  // Both banks read the same low address; the bank select travels down the
  // pipeline and picks the result at the output mux.
  nco_bank #(.AW(ADDR_W), .DW(DATA_W)) u_bank0 (
    .clk   (clk),
    .we    (we0),
    .waddr (wr_addr[ADDR_W-1:0]),
    .wdata (wr_data),
    .re    (issue),
    .raddr (rd_addr),
    .rdata (rdata0)
  );

  nco_bank #(.AW(ADDR_W), .DW(DATA_W)) u_bank1 (
    .clk   (clk),
    .we    (we1),
    .waddr (wr_addr[ADDR_W-1:0]),
    .wdata (wr_data),
    .re    (issue),
    .raddr (rd_addr),
    .rdata (rdata1)
  );

  // ---------------------------------------------------------------------------
  // Read pipeline
  // ---------------------------------------------------------------------------
  logic              vld_a;
  logic              sel_a;
  logic              vld_b;
  logic              sel_b;
  logic [DATA_W-1:0] q0_b;
  logic [DATA_W-1:0] q1_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_a <= 1'b0;
      sel_a <= 1'b0;
    end else begin
      vld_a <= issue;
      sel_a <= rd_bank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_b <= 1'b0;
      sel_b <= 1'b0;
      q0_b  <= '0;
      q1_b  <= '0;
    end else begin
      vld_b <= vld_a;
      sel_b <= sel_a;
      if (vld_a) begin
        q0_b <= rdata0;
        q1_b <= rdata1;
      end
    end
  end

  // sine_out holds its last sample while nothing new is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sine_out   <= '0;
      sine_valid <= 1'b0;
    end else begin
      sine_valid <= vld_b;
      if (vld_b) sine_out <= sel_b ? q1_b : q0_b;
    end
  end

endmodule

// File: tb/tb_nco_phase_core.sv
module tb_nco_phase_core;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        phase_clr;
  logic [16:0] ftw;
  logic [9:0]  len;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [15:0] wr_data;
  logic [15:0] sine_out;
  logic        sine_valid;
  logic        wrap;

  int n_checks = 0;
  int n_fail   = 0;

  nco_phase_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .phase_clr  (phase_clr),
    .ftw        (ftw),
    .len        (len),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .sine_out   (sine_out),
    .sine_valid (sine_valid),
    .wrap       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: phase as a plain integer, table as an int array, and a
  // queue holding the samples issued on the last edges (2-edge latency).
  // ---------------------------------------------------------------------------
  typedef struct {bit v; int d;} item_t;

  int       m_p;
  int       tbl [512];
  item_t    pipe [$];
  bit [15:0] exp_out;
  bit       exp_valid;
  bit       exp_wrap;

  task automatic model_reset();
    m_p       = 0;
    pipe.delete();
    exp_out   = '0;
    exp_valid = 1'b0;
    exp_wrap  = 1'b0;
  endtask

  // Advance model by one edge using the currently driven inputs, then let
  // the DUT take that same edge. Returns 1 ns after the edge.
  task automatic step();
    int    len_eff, m, s, t;
    bit    oor, iss;
    item_t it, o;
    len_eff = (len == 0) ? 1 : int'(len);
    m   = len_eff * 256;
    s   = (int'(ftw) < m) ? int'(ftw) : 0;
    oor = (m_p >= m);
    iss = en && !oor;
    it.v = iss;
    it.d = iss ? tbl[m_p / 256] : 0;
    if (phase_clr) begin
      m_p = 0; exp_wrap = 1'b0;
    end else if (oor) begin
      m_p = 0; exp_wrap = 1'b1;
    end else if (en) begin
      t = m_p + s;
      exp_wrap = (t >= m);
      m_p = exp_wrap ? t - m : t;
    end else begin
      exp_wrap = 1'b0;
    end
    if (wr_en) tbl[wr_addr] = int'(wr_data);
    pipe.push_back(it);
    if (pipe.size() > 2) begin
      o = pipe.pop_front();
      exp_valid = o.v;
      if (o.v) exp_out = 16'(o.d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_identity();
    en = 1'b0;
    for (int i = 0; i < 512; i++) begin
      wr_en = 1'b1; wr_addr = 9'(i); wr_data = 16'(i);
      step();
    end
    wr_en = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; phase_clr = 1'b0; ftw = '0; len = 10'd512;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    model_reset();
    #12;
    n_checks++;
    if (sine_out !== 16'h0) begin
      n_fail++; $display("FAIL reset_out got=%h want=0000", sine_out);
    end
    n_checks++;
    if (sine_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got=%b want=0", sine_valid);
    end
    n_checks++;
    if (wrap !== 1'b0) begin
      n_fail++; $display("FAIL reset_wrap got=%b want=0", wrap);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_identity_sweep();
    int n_wrap = 0;
    ftw = 17'h100; len = 10'd512;
    phase_clr = 1'b1; step(); phase_clr = 1'b0;
    en = 1'b1;
    for (int c = 0; c < 520; c++) begin
      step();
      if (wrap === 1'b1) n_wrap++;
      n_checks++;
      if (sine_out !== exp_out || sine_valid !== exp_valid || wrap !== exp_wrap) begin
        n_fail++;
        $display("FAIL identity c=%0d out=%h/%h valid=%b/%b wrap=%b/%b",
                 c, sine_out, exp_out, sine_valid, exp_valid, wrap, exp_wrap);
      end
    end
    n_checks++;
    if (n_wrap != 1) begin
      n_fail++; $display("FAIL identity_wrap_count got=%0d want=1", n_wrap);
    end
    en = 1'b0;
  endtask

  task automatic test_fractional();
    ftw = 17'h180; len = 10'd10;
    phase_clr = 1'b1; step(); phase_clr = 1'b0;
    en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      n_checks++;
      if (sine_out !== exp_out || sine_valid !== exp_valid || wrap !== exp_wrap) begin
        n_fail++;
        $display("FAIL fractional c=%0d out=%h/%h valid=%b/%b wrap=%b/%b",
                 c, sine_out, exp_out, sine_valid, exp_valid, wrap, exp_wrap);
      end
    end
  endtask

  task automatic test_ftw_hold();
    ftw = 17'h0A00; len = 10'd10;
    phase_clr = 1'b1; step(); phase_clr = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      n_checks++;
      if (sine_out !== exp_out || sine_valid !== exp_valid || wrap !== exp_wrap ||
          (c >= 2 && sine_out !== 16'h0)) begin
        n_fail++;
        $display("FAIL ftw_hold c=%0d out=%h/%h valid=%b/%b wrap=%b/%b",
                 c, sine_out, exp_out, sine_valid, exp_valid, wrap, exp_wrap);
      end
    end
    len = 10'd512;
    for (int c = 0; c < 12; c++) begin
      step();
      n_checks++;
      if (sine_out !== exp_out || sine_valid !== exp_valid || wrap !== exp_wrap) begin
        n_fail++;
        $display("FAIL ftw_resume c=%0d out=%h/%h valid=%b/%b wrap=%b/%b",
                 c, sine_out, exp_out, sine_valid, exp_valid, wrap, exp_wrap);
      end
    end
  endtask

  task automatic test_len_shrink();
    int guard = 0;
    ftw = 17'h100; len = 10'd512;
    phase_clr = 1'b1; step(); phase_clr = 1'b0;
    while (m_p != 300 * 256 && guard < 400) begin
      step(); guard++;
    end
    n_checks++;
    if (guard >= 400) begin
      n_fail++; $display("FAIL shrink_reach got=%0d want=%0d", m_p, 300 * 256);
    end
    len = 10'd200;
    step();
    n_checks++;
    if (wrap !== 1'b1 || exp_wrap !== 1'b1) begin
      n_fail++; $display("FAIL shrink_wrap got=%b want=1", wrap);
    end
    for (int c = 0; c < 12; c++) begin
      step();
      n_checks++;
      if (sine_out !== exp_out || sine_valid !== exp_valid || wrap !== exp_wrap ||
          (sine_valid === 1'b1 && sine_out === 16'd300)) begin
        n_fail++;
        $display("FAIL shrink c=%0d out=%h/%h valid=%b/%b wrap=%b/%b",
                 c, sine_out, exp_out, sine_valid, exp_valid, wrap, exp_wrap);
      end
    end
  endtask

  task automatic test_collision();
    bit done = 1'b0, seen_old = 1'b0, seen_new = 1'b0;
    ftw = 17'h100; len = 10'd10;
    phase_clr = 1'b1; step(); phase_clr = 1'b0;
    en = 1'b1;
    for (int c = 0; c < 26; c++) begin
      if (!done && (m_p / 256) == 5) begin
        wr_en = 1'b1; wr_addr = 9'd5; wr_data = 16'hBEEF; done = 1'b1;
      end
      step();
      wr_en = 1'b0;
      if (done && sine_valid === 1'b1 && sine_out === 16'd5) seen_old = 1'b1;
      if (seen_old && sine_valid === 1'b1 && sine_out === 16'hBEEF) seen_new = 1'b1;
      n_checks++;
      if (sine_out !== exp_out || sine_valid !== exp_valid || wrap !== exp_wrap) begin
        n_fail++;
        $display("FAIL collision c=%0d out=%h/%h valid=%b/%b wrap=%b/%b",
                 c, sine_out, exp_out, sine_valid, exp_valid, wrap, exp_wrap);
      end
    end
    n_checks++;
    if (!(seen_old && seen_new)) begin
      n_fail++; $display("FAIL collision_order got old=%b new=%b want old=1 new=1", seen_old, seen_new);
    end
    en = 1'b0;
    wr_en = 1'b1; wr_addr = 9'd5; wr_data = 16'd5; step(); wr_en = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int       first_c = -1;
    logic [15:0] held;
    ftw = 17'h100; len = 10'd512; en = 1'b1;
    for (int c = 0; c < 20; c++) step();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (sine_out !== 16'h0 || sine_valid !== 1'b0 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset out=%h valid=%b wrap=%b want 0/0/0", sine_out, sine_valid, wrap);
    end
    #2 rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (first_c < 0 && sine_valid === 1'b1) begin
        first_c = c;
        n_checks++;
        if (sine_out !== 16'd0) begin
          n_fail++; $display("FAIL first_sample got=%h want=0000", sine_out);
        end
      end
      n_checks++;
      if (sine_out !== exp_out || sine_valid !== exp_valid || wrap !== exp_wrap) begin
        n_fail++;
        $display("FAIL post_reset c=%0d out=%h/%h valid=%b/%b wrap=%b/%b",
                 c, sine_out, exp_out, sine_valid, exp_valid, wrap, exp_wrap);
      end
    end
    n_checks++;
    if (first_c != 2) begin
      n_fail++; $display("FAIL first_latency got=%0d want=2", first_c);
    end
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (sine_valid !== (c < 2 ? 1'b1 : 1'b0) || sine_out !== exp_out) begin
        n_fail++;
        $display("FAIL en_drain c=%0d valid=%b out=%h/%h", c, sine_valid, sine_out, exp_out);
      end
    end
    held = sine_out;
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++;
      if (sine_out !== held || sine_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL en_freeze c=%0d out=%h/%h valid=%b/0", c, sine_out, held, sine_valid);
      end
    end
  endtask

  task automatic test_random();
    int le, f;
    for (int c = 0; c < 600; c++) begin
      if (c % 40 == 0) begin
        len = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 512));
        le  = (len == 0) ? 1 : int'(len);
        f   = int'($urandom_range(0, le * 256 + 256));
        if (f > 131071) f = 131071;
        ftw = 17'(f);
      end
      en        = ($urandom_range(0, 9) < 8);
      phase_clr = ($urandom_range(0, 31) == 0);
      wr_en     = ($urandom_range(0, 9) == 0);
      wr_addr   = 9'($urandom_range(0, 511));
      wr_data   = 16'($urandom);
      step();
      n_checks++;
      if (sine_out !== exp_out || sine_valid !== exp_valid || wrap !== exp_wrap) begin
        n_fail++;
        $display("FAIL random c=%0d out=%h/%h valid=%b/%b wrap=%b/%b",
                 c, sine_out, exp_out, sine_valid, exp_valid, wrap, exp_wrap);
      end
    end
    en = 1'b0; phase_clr = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    test_reset();
    load_identity();
    test_identity_sweep();
    test_fractional();
    test_ftw_hold();
    test_len_shrink();
    test_collision();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
